// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data memory with load/store front end.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  function automatic logic [31:0] sext8(input logic [7:0] b);
    return {{24{b[7]}}, b};
  endfunction

  function automatic logic [31:0] sext16(input logic [15:0] h);
    return {{16{h[15]}}, h};
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store byte enables and replicated data, and load lane
// extraction with sign/zero extension. Sizes other than byte/half act as word.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    rdata_o = rword_i;
    rbyte   = rword_i[8*addr_lo_i +: 8];
    // addr[0] is ignored for halves, so a misaligned half lands on its aligned pair.
    rhalf   = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
    case (size_i)
      SZ_B: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = unsigned_i ? {24'b0, rbyte} : sext8(rbyte);
      end
      SZ_H: begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = unsigned_i ? {16'b0, rhalf} : sext16(rhalf);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_lsu.sv
// Data memory with a valid/ready load/store front end and programmable latency.
// Optional DMEM_MISALIGN_TRAP_EN flags misaligned/reserved/out-of-range accesses.
module data_mem_lsu
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output dmem_state_e       dbg_state
);

  localparam int         IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [2:0] WAIT_LOAD = 3'(WAIT_STATES - 1);

  dmem_state_e       state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              we_q, uns_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              resp_valid_q;
  logic [31:0]       resp_rdata_q;
  logic              resp_err_q;

  logic [31:0]       mem_q [DEPTH_WORDS];

  logic              accept;
  logic [IDX_W-1:0]  idx;
  logic              in_range;
  logic              fault;
  logic              err_flag;
  logic [3:0]        be;
  logic [31:0]       wdata_al;
  logic [31:0]       rdata_ext;

  // Handshake: a request transfers on a cycle where req_valid && req_ready;
  // req_ready is high only in IDLE and never while rst is asserted. Responses
  // cannot be stalled: resp_valid is a single-cycle pulse.
  assign req_ready = !rst && (state_q == IDLE);
  assign accept    = req_valid && req_ready;

  assign idx      = addr_q[IDX_W+1:2];
  assign in_range = (addr_q >> (IDX_W + 2)) == '0;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign fault    = !in_range || (size_q == 2'b11) ||
                    ((size_q == SZ_H) && addr_q[0]) ||
                    ((size_q == SZ_W) && (addr_q[1:0] != 2'b00));
  assign err_flag = fault;
`else
  assign fault    = !in_range;
  assign err_flag = 1'b0;
`endif

  dmem_lane_align u_align (
    .size_i     (size_q),
    .addr_lo_i  (addr_q[1:0]),
    .unsigned_i (uns_q),
    .wdata_i    (wdata_q),
    .rword_i    (mem_q[idx]),
    .be_o       (be),
    .wdata_o    (wdata_al),
    .rdata_o    (rdata_ext)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 3'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 3'd0;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      size_q       <= 2'b00;
      addr_q       <= '0;
      wdata_q      <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= (state_q == RESP);
      if (accept) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state_q == RESP) begin
        resp_rdata_q <= (we_q || fault) ? 32'd0 : rdata_ext;
        resp_err_q   <= err_flag;
      end
    end
  end

  // The array is deliberately outside the reset domain; the rst gate keeps an
  // abandoned store from committing.
  always_ff @(posedge clk) begin
    if (!rst && (state_q == RESP) && we_q && !fault) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[idx][8*b +: 8] <= wdata_al[8*b +: 8];
      end
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench: instance 0 uses one wait state, instance 1 uses none.
module tb_data_mem_lsu;
  import dmem_pkg::*;

`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        req_valid    [2];
  logic        req_ready    [2];
  logic        req_we       [2];
  logic [1:0]  req_size     [2];
  logic        req_unsigned [2];
  logic [31:0] req_addr     [2];
  logic [31:0] req_wdata    [2];
  logic        resp_valid   [2];
  logic [31:0] resp_rdata   [2];
  logic        resp_err     [2];
  dmem_state_e dbg_state    [2];

  int n_checks = 0;
  int n_errors = 0;

  data_mem_lsu #(.ADDR_W(32), .DEPTH_WORDS(256), .WAIT_STATES(1)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]),
    .resp_err(resp_err[0]), .dbg_state(dbg_state[0])
  );

  data_mem_lsu #(.ADDR_W(32), .DEPTH_WORDS(256), .WAIT_STATES(0)) u_dut_ws0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]),
    .resp_err(resp_err[1]), .dbg_state(dbg_state[1])
  );

  // Clock and timeout
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request on instance d and collect its response.
  task automatic do_req(input int d, input string tag, input logic we, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                        input int exp_lat, output logic [31:0] rd, output logic er);
    int guard;
    int lat;
    guard = 0;
    while (!req_ready[d] && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check({tag, " ready"}, {31'b0, req_ready[d]}, 32'd1);
    req_valid[d]    = 1'b1;
    req_we[d]       = we;
    req_size[d]     = sz;
    req_unsigned[d] = uns;
    req_addr[d]     = addr;
    req_wdata[d]    = wd;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!resp_valid[d] && lat < 20);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    rd = resp_rdata[d];
    er = resp_err[d];
    check({tag, " ready_in_resp"}, {31'b0, req_ready[d]}, 32'd1);
    @(posedge clk); #1;
    check({tag, " pulse_width"}, {31'b0, resp_valid[d]}, 32'd0);
  endtask

  logic [31:0] rd;
  logic        er;
  logic        seen;

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_valid[d]    = 1'b1;
      req_we[d]       = 1'b1;
      req_size[d]     = 2'b10;
      req_unsigned[d] = 1'b0;
      req_addr[d]     = 32'd0;
      req_wdata[d]    = 32'hFFFF_FFFF;
    end

    // Reset held with a request pending
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      check("rst ready", {31'b0, req_ready[0]}, 32'd0);
      check("rst resp_valid", {31'b0, resp_valid[0]}, 32'd0);
      check("rst rdata", resp_rdata[0], 32'd0);
      check("rst err", {31'b0, resp_err[0]}, 32'd0);
      check("rst state", {30'b0, dbg_state[0]}, {30'b0, IDLE});
    end
    rst = 1'b0;
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b0;
    #1;
    check("post_rst ready0", {31'b0, req_ready[0]}, 32'd1);
    check("post_rst ready1", {31'b0, req_ready[1]}, 32'd1);

    // Word store/load round trip
    do_req(0, "sw44", 1'b1, 2'b10, 1'b0, 32'd44, 32'hAAAA_FFFF, 2, rd, er);
    check("sw44 rdata", rd, 32'd0);
    check("sw44 err", {31'b0, er}, 32'd0);
    do_req(0, "lw44", 1'b0, 2'b10, 1'b0, 32'd44, 32'd0, 2, rd, er);
    check("lw44 rdata", rd, 32'hAAAA_FFFF);

    // Byte store and signed/unsigned byte loads
    do_req(0, "sb45", 1'b1, 2'b00, 1'b0, 32'd45, 32'h0000_0080, 2, rd, er);
    do_req(0, "lb45", 1'b0, 2'b00, 1'b0, 32'd45, 32'd0, 2, rd, er);
    check("lb45 rdata", rd, 32'hFFFF_FF80);
    do_req(0, "lbu45", 1'b0, 2'b00, 1'b1, 32'd45, 32'd0, 2, rd, er);
    check("lbu45 rdata", rd, 32'h0000_0080);
    do_req(0, "lw44b", 1'b0, 2'b10, 1'b0, 32'd44, 32'd0, 2, rd, er);
    check("lw44b rdata", rd, 32'hAAAA_80FF);
    do_req(0, "lh44", 1'b0, 2'b01, 1'b0, 32'd44, 32'd0, 2, rd, er);
    check("lh44 rdata", rd, 32'hFFFF_80FF);
    do_req(0, "lhu44", 1'b0, 2'b01, 1'b1, 32'd44, 32'd0, 2, rd, er);
    check("lhu44 rdata", rd, 32'h0000_80FF);

    // Half store, upper lanes, out-of-range load
    do_req(0, "sh46", 1'b1, 2'b01, 1'b0, 32'd46, 32'h0000_1234, 2, rd, er);
    do_req(0, "lw44c", 1'b0, 2'b10, 1'b0, 32'd44, 32'd0, 2, rd, er);
    check("lw44c rdata", rd, 32'h1234_80FF);
    do_req(0, "lh46", 1'b0, 2'b01, 1'b0, 32'd46, 32'd0, 2, rd, er);
    check("lh46 rdata", rd, 32'h0000_1234);
    do_req(0, "lb47", 1'b0, 2'b00, 1'b0, 32'd47, 32'd0, 2, rd, er);
    check("lb47 rdata", rd, 32'h0000_0012);
    do_req(0, "lw4096", 1'b0, 2'b10, 1'b0, 32'd4096, 32'd0, 2, rd, er);
    check("lw4096 rdata", rd, 32'd0);
    check("lw4096 err", {31'b0, er}, {31'b0, TRAP});

    // Misaligned accesses
    do_req(0, "sw20", 1'b1, 2'b10, 1'b0, 32'd20, 32'h5A5A_5A5A, 2, rd, er);
    do_req(0, "lw22", 1'b0, 2'b10, 1'b0, 32'd22, 32'd0, 2, rd, er);
    check("lw22 rdata", rd, TRAP ? 32'd0 : 32'h5A5A_5A5A);
    check("lw22 err", {31'b0, er}, {31'b0, TRAP});
    do_req(0, "sh45", 1'b1, 2'b01, 1'b0, 32'd45, 32'h0000_7777, 2, rd, er);
    check("sh45 err", {31'b0, er}, {31'b0, TRAP});
    do_req(0, "lw44d", 1'b0, 2'b10, 1'b0, 32'd44, 32'd0, 2, rd, er);
    check("lw44d rdata", rd, TRAP ? 32'h1234_80FF : 32'h1234_7777);

    // Reserved size behaves as word or traps
    do_req(0, "lsz3", 1'b0, 2'b11, 1'b0, 32'd44, 32'd0, 2, rd, er);
    check("lsz3 rdata", rd, TRAP ? 32'd0 : 32'h1234_7777);
    check("lsz3 err", {31'b0, er}, {31'b0, TRAP});

    // Last in-range word, then an out-of-range store that must not alias word 0
    do_req(0, "sw1020", 1'b1, 2'b10, 1'b0, 32'd1020, 32'h0F0E_0D0C, 2, rd, er);
    do_req(0, "lw1020", 1'b0, 2'b10, 1'b0, 32'd1020, 32'd0, 2, rd, er);
    check("lw1020 rdata", rd, 32'h0F0E_0D0C);
    check("lw1020 err", {31'b0, er}, 32'd0);
    do_req(0, "sw0", 1'b1, 2'b10, 1'b0, 32'd0, 32'h1111_1111, 2, rd, er);
    do_req(0, "sw1024", 1'b1, 2'b10, 1'b0, 32'd1024, 32'hBADB_AD00, 2, rd, er);
    check("sw1024 err", {31'b0, er}, {31'b0, TRAP});
    do_req(0, "lw0", 1'b0, 2'b10, 1'b0, 32'd0, 32'd0, 2, rd, er);
    check("lw0 rdata", rd, 32'h1111_1111);

    // Store abandoned by reset during its wait cycle
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_size[0]  = 2'b10;
    req_addr[0]  = 32'd0;
    req_wdata[0] = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    check("abort in_wait", {30'b0, dbg_state[0]}, {30'b0, WAIT});
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort state", {30'b0, dbg_state[0]}, {30'b0, IDLE});
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      seen = seen | resp_valid[0];
    end
    check("abort no_resp", {31'b0, seen}, 32'd0);
    do_req(0, "lw0b", 1'b0, 2'b10, 1'b0, 32'd0, 32'd0, 2, rd, er);
    check("lw0b rdata", rd, 32'h1111_1111);

    // Zero-wait-state instance
    do_req(1, "ws0 sw8", 1'b1, 2'b10, 1'b0, 32'd8, 32'hCAFE_F00D, 1, rd, er);
    check("ws0 sw8 rdata", rd, 32'd0);
    do_req(1, "ws0 lw8", 1'b0, 2'b10, 1'b0, 32'd8, 32'd0, 1, rd, er);
    check("ws0 lw8 rdata", rd, 32'hCAFE_F00D);
    do_req(1, "ws0 lhu10", 1'b0, 2'b01, 1'b1, 32'd10, 32'd0, 1, rd, er);
    check("ws0 lhu10 rdata", rd, 32'h0000_CAFE);
    do_req(1, "ws0 lb9", 1'b0, 2'b00, 1'b0, 32'd9, 32'd0, 1, rd, er);
    check("ws0 lb9 rdata", rd, 32'hFFFF_FFF0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
